// File: rtl/multdiv_sequencer.sv
// Sequencer for the shared mult/div unit: decodes R-type mul/div, pulses the unit,
// stalls the front end until the result (or a timeout) returns, then writes it back.
module multdiv_sequencer #(
  parameter int unsigned MAX_CYCLES   = 40,
  parameter int unsigned CNT_W        = 6,
  parameter int unsigned RSTATUS_REG  = 30,
  parameter int unsigned MUL_EXC_CODE = 4,
  parameter int unsigned DIV_EXC_CODE = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  opCode,
  input  logic [4:0]  aluOp,
  input  logic [4:0]  rd,
  input  logic        data_resultRDY,
  input  logic        data_exception,
  input  logic [31:0] data_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        busy,
  output logic        md_we,
  output logic [4:0]  md_wreg,
  output logic [31:0] md_wdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_WB
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              op_div;
  logic [4:0]        rd_q;
  logic [31:0]       res_q;
  logic              exc_q;

  logic is_mul;
  logic is_div;

  assign is_mul = (opCode == 5'b00000) && (aluOp == 5'b00110);
  assign is_div = (opCode == 5'b00000) && (aluOp == 5'b00111);

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_div <= 1'b0;
      rd_q   <= '0;
      res_q  <= '0;
      exc_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mul || is_div) begin
            op_div <= is_div;
            rd_q   <= rd;
            cnt    <= '0;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt <= cnt + 1'b1;
          // A result arriving on the timeout cycle takes priority over the timeout.
          if (data_resultRDY) begin
            res_q <= data_result;
            exc_q <= data_exception;
            state <= S_WB;
          end else if (cnt == CNT_W'(MAX_CYCLES - 1)) begin
            exc_q <= 1'b1;
            state <= S_WB;
          end
        end
        S_WB: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from state so that reset forces them low within the same cycle.
  always_comb begin
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    stall     = 1'b0;
    busy      = 1'b0;
    md_we     = 1'b0;
    md_wreg   = '0;
    md_wdata  = '0;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          ctrl_MULT = is_mul;
          ctrl_DIV  = is_div;
          stall     = is_mul | is_div;
        end
        S_BUSY: begin
          stall = 1'b1;
          busy  = 1'b1;
        end
        S_WB: begin
          busy = 1'b1;
          if (exc_q) begin
            md_we    = 1'b1;
            md_wreg  = 5'(RSTATUS_REG);
            md_wdata = op_div ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
          end else if (rd_q != '0) begin
            md_we    = 1'b1;
            md_wreg  = rd_q;
            md_wdata = res_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: transaction-level expectations
// derived from issue/latency rules, checked every cycle by one compare process.
module tb_multdiv_sequencer;

  localparam int MAXC = 40;

  logic        clock;
  logic        reset;
  logic [4:0]  opCode;
  logic [4:0]  aluOp;
  logic [4:0]  rd;
  logic        data_resultRDY;
  logic        data_exception;
  logic [31:0] data_result;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall;
  logic        busy;
  logic        md_we;
  logic [4:0]  md_wreg;
  logic [31:0] md_wdata;

  multdiv_sequencer #(
    .MAX_CYCLES  (40),
    .CNT_W       (6),
    .RSTATUS_REG (30),
    .MUL_EXC_CODE(4),
    .DIV_EXC_CODE(5)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .opCode        (opCode),
    .aluOp         (aluOp),
    .rd            (rd),
    .data_resultRDY(data_resultRDY),
    .data_exception(data_exception),
    .data_result   (data_result),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .stall         (stall),
    .busy          (busy),
    .md_we         (md_we),
    .md_wreg       (md_wreg),
    .md_wdata      (md_wdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Expected outputs for the current cycle, written by the driver.
  logic        chk_en = 1'b0;
  logic        e_mult, e_div, e_stall, e_busy, e_we;
  logic [4:0]  e_wreg;
  logic [31:0] e_wdata;

  // Observation records kept by the compare process, read by literal checks.
  int          stall_run = 0;
  int          last_stall_run = 0;
  int          wr_count = 0;
  int          wr7_count = 0;
  logic [4:0]  last_wreg = '0;
  logic [31:0] last_wdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("ctrl_MULT", 32'(ctrl_MULT), 32'(e_mult));
      check("ctrl_DIV",  32'(ctrl_DIV),  32'(e_div));
      check("stall",     32'(stall),     32'(e_stall));
      check("busy",      32'(busy),      32'(e_busy));
      check("md_we",     32'(md_we),     32'(e_we));
      check("md_wreg",   32'(md_wreg),   32'(e_wreg));
      check("md_wdata",  md_wdata,       e_wdata);
      if (stall === 1'b1) stall_run++;
      else if (stall_run != 0) begin
        last_stall_run = stall_run;
        stall_run = 0;
      end
      if (md_we === 1'b1) begin
        wr_count++;
        if (md_wreg == 5'd7) wr7_count++;
        last_wreg  = md_wreg;
        last_wdata = md_wdata;
      end
    end
  end

  task automatic set_exp(input logic m, input logic d, input logic s, input logic b,
                         input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
    e_mult = m; e_div = d; e_stall = s; e_busy = b;
    e_we = we; e_wreg = wreg; e_wdata = wdata;
    chk_en = 1'b1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_noise();
    data_resultRDY = 1'($urandom);
    data_exception = 1'($urandom);
    data_result    = $urandom;
    rd             = 5'($urandom);
  endtask

  task automatic rand_non_md();
    opCode = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
    aluOp  = 5'($urandom);
    if (opCode == 5'd0 && (aluOp == 5'd6 || aluOp == 5'd7)) aluOp = 5'd0;
  endtask

  task automatic idle_cycle();
    reset = 1'b0;
    rand_non_md();
    rand_noise();
    set_exp(0, 0, 0, 0, 0, '0, '0);
    step();
  endtask

  task automatic reset_cycle();
    reset = 1'b1;
    opCode = 5'd0;
    aluOp  = ($urandom_range(0, 1) == 0) ? 5'd6 : 5'd7;
    rand_noise();
    set_exp(0, 0, 0, 0, 0, '0, '0);
    step();
  endtask

  // One mul/div transaction. rdy_at: BUSY cycle index (1-based) carrying the result,
  // 0 or >MAXC means none; rst_at: BUSY cycle index in which reset is pulsed, 0 = none.
  task automatic do_op(input logic is_div, input logic [4:0] rdv, input int rdy_at,
                       input logic exc, input logic [31:0] res, input int rst_at);
    logic        exc_f;
    logic [31:0] res_f;
    logic        we;
    exc_f = 1'b0;
    res_f = '0;
    reset = 1'b0;
    opCode = 5'd0;
    aluOp  = is_div ? 5'd7 : 5'd6;
    rand_noise();
    rd = rdv;
    set_exp(!is_div, is_div, 1, 0, 0, '0, '0);
    step();
    for (int i = 1; i <= MAXC; i++) begin
      if (i == rst_at) begin
        reset_cycle();
        reset = 1'b0;
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        opCode = 5'd0;
        aluOp  = 5'($urandom_range(6, 7));
      end else rand_non_md();
      rand_noise();
      data_resultRDY = (i == rdy_at);
      if (i == rdy_at) begin
        data_exception = exc;
        data_result    = res;
      end
      set_exp(0, 0, 1, 1, 0, '0, '0);
      step();
      if (i == rdy_at) begin
        exc_f = exc;
        res_f = res;
        break;
      end
      if (i == MAXC) exc_f = 1'b1;
    end
    // Write-back cycle: inputs may even decode as mul/div and must not start anything.
    opCode = 5'd0;
    aluOp  = 5'($urandom_range(5, 7));
    rand_noise();
    if (exc_f) set_exp(0, 0, 0, 1, 1, 5'd30, is_div ? 32'd5 : 32'd4);
    else begin
      we = (rdv != 5'd0);
      set_exp(0, 0, 0, 1, we, we ? rdv : 5'd0, we ? res_f : 32'd0);
    end
    step();
  endtask

  initial begin
    int wc;
    int w7;
    reset = 1'b1;
    opCode = '0; aluOp = '0; rd = '0;
    data_resultRDY = 1'b0; data_exception = 1'b0; data_result = '0;

    // Reset held with a mul decoded on the inputs.
    for (int i = 0; i < 3; i++) begin
      reset = 1'b1;
      opCode = 5'd0; aluOp = 5'd6;
      rand_noise();
      set_exp(0, 0, 0, 0, 0, '0, '0);
      step();
    end

    // mul rd=5, result on the 17th BUSY cycle; first cycle out of reset issues it.
    do_op(1'b0, 5'd5, 17, 1'b0, 32'h0000_0F00, 0);
    check("lit_stall_len", 32'(last_stall_run), 32'd18);
    check("lit_mul_wreg", 32'(last_wreg), 32'd5);
    check("lit_mul_wdata", last_wdata, 32'h0000_0F00);
    idle_cycle();

    // div rd=7 with exception: status register gets the div code, r7 untouched.
    w7 = wr7_count;
    do_op(1'b1, 5'd7, 6, 1'b1, 32'hDEAD_BEEF, 0);
    check("lit_divexc_wreg", 32'(last_wreg), 32'd30);
    check("lit_divexc_wdata", last_wdata, 32'd5);
    check("lit_no_r7", 32'(wr7_count - w7), 32'd0);
    idle_cycle();

    // mul rd=0: no write at all.
    wc = wr_count;
    do_op(1'b0, 5'd0, 3, 1'b0, 32'h0000_1234, 0);
    check("lit_rd0_nowrite", 32'(wr_count - wc), 32'd0);
    idle_cycle();

    // div timeout, then result on the last permitted BUSY cycle.
    do_op(1'b1, 5'd9, 0, 1'b0, 32'd0, 0);
    check("lit_timeout_wreg", 32'(last_wreg), 32'd30);
    check("lit_timeout_wdata", last_wdata, 32'd5);
    do_op(1'b1, 5'd9, 40, 1'b0, 32'hCAFE_0040, 0);
    check("lit_rdy40_wreg", 32'(last_wreg), 32'd9);
    check("lit_rdy40_wdata", last_wdata, 32'hCAFE_0040);

    // Reset in the 10th BUSY cycle, then a late RDY with an add in IDLE.
    wc = wr_count;
    do_op(1'b0, 5'd3, 0, 1'b0, 32'd0, 10);
    idle_cycle();
    reset = 1'b0;
    opCode = 5'd0; aluOp = 5'd0; rd = 5'd3;
    data_resultRDY = 1'b1; data_exception = 1'b0; data_result = 32'h5555_AAAA;
    set_exp(0, 0, 0, 0, 0, '0, '0);
    step();
    check("lit_reset_nowrite", 32'(wr_count - wc), 32'd0);

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      int k;
      int ra;
      k  = $urandom_range(1, 45);
      ra = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 12) : 0;
      do_op(1'($urandom), 5'($urandom), (k > MAXC) ? 0 : k,
            ($urandom_range(0, 3) == 0), $urandom, ra);
      for (int j = $urandom_range(0, 3); j > 0; j--) idle_cycle();
      if ($urandom_range(0, 15) == 0) reset_cycle();
    end

    idle_cycle();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
